// File: rtl/ad9361_cfg_seq.sv
// Table-driven AD9361 register configuration sequencer: WRITE / WAIT / POLL / END commands.
// Optional build macro CFG_READBACK_EN: every WRITE is verified by reading the register back.
module ad9361_cfg_seq #(
  parameter int TBL_AW    = 8,
  parameter int WAIT_UNIT = 1000,
  parameter int POLL_MAX  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [19:0]       tbl_data,
  output logic              wr_req,
  input  logic              wr_end,
  output logic [9:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_req,
  input  logic              rd_end,
  output logic [9:0]        rd_addr,
  input  logic [7:0]        rd_data
);

`ifdef CFG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  localparam logic [23:0] WAIT_UNIT_W = 24'(WAIT_UNIT);
  localparam logic [8:0]  POLL_MAX_W  = 9'(POLL_MAX);
  localparam logic [1:0]  ERR_POLL    = 2'b01;
  localparam logic [1:0]  ERR_RDBK    = 2'b10;
  localparam logic [1:0]  ERR_OVR     = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR, S_WR_WAIT, S_DLY,
    S_RD, S_RD_WAIT, S_CHECK, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_WAIT  = 2'b01,
    OP_POLL  = 2'b10,
    OP_END   = 2'b11
  } op_e;

  state_e              state_q, state_d;
  op_e                 op_q, op_d, tbl_op;
  logic [TBL_AW-1:0]   ptr_q, ptr_d;
  logic [9:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          rd_q, rd_d;
  logic [23:0]         cnt_q, cnt_d;
  logic [7:0]          retry_q, retry_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;
  logic                advance, fail;
  logic [1:0]          fail_code;

  assign tbl_op = op_e'(tbl_data[19:18]);

  // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    err_d     = err_q;
    code_d    = code_q;
    advance   = 1'b0;
    fail      = 1'b0;
    fail_code = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          ptr_d   = '0;
          err_d   = 1'b0;
          code_d  = 2'b00;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        op_d   = tbl_op;
        addr_d = tbl_data[17:8];
        data_d = tbl_data[7:0];
        case (tbl_op)
          OP_WRITE: state_d = S_WR;
          OP_WAIT: begin
            cnt_d   = {16'd0, tbl_data[7:0]} * WAIT_UNIT_W;
            state_d = S_DLY;
          end
          OP_POLL: begin
            retry_d = 8'd0;
            state_d = S_RD;
          end
          OP_END:  state_d = S_DONE;
        endcase
      end
      S_WR: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (wr_end) begin
          if (READBACK) state_d = S_RD;
          else          advance = 1'b1;
        end
      end
      // A zero or one count both leave after a single DLY cycle.
      S_DLY: begin
        if (cnt_q <= 24'd1) advance = 1'b1;
        else                cnt_d   = cnt_q - 24'd1;
      end
      S_RD: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_end) begin
          rd_d    = rd_data;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q == OP_WRITE) begin
          if (rd_q == data_q) advance = 1'b1;
          else begin
            fail      = 1'b1;
            fail_code = ERR_RDBK;
          end
        end else if ((rd_q & data_q) == data_q) begin
          advance = 1'b1;
        end else if (({1'b0, retry_q} + 9'd1) == POLL_MAX_W) begin
          fail      = 1'b1;
          fail_code = ERR_POLL;
        end else begin
          retry_d = retry_q + 8'd1;
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The last table entry may only hold END; the pointer never wraps.
    if (advance) begin
      if (&ptr_q) begin
        fail      = 1'b1;
        fail_code = ERR_OVR;
      end else begin
        ptr_d   = ptr_q + TBL_AW'(1);
        state_d = S_FETCH;
      end
    end

    if (fail) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      code_d  = fail_code;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_WRITE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done     = (state_q == S_DONE);
  assign wr_req   = (state_q == S_WR);
  assign rd_req   = (state_q == S_RD);
  assign err      = err_q;
  assign err_code = code_q;
  assign tbl_addr = ptr_q;
  assign wr_addr  = addr_q;
  assign wr_data  = data_q;
  assign rd_addr  = addr_q;

endmodule

// File: tb/tb_ad9361_cfg_seq.sv
// Self-checking bench for ad9361_cfg_seq: directed scenarios plus random tables scored
// against a table-walking reference model; SPI master modelled by a latency-randomised responder.
module tb_ad9361_cfg_seq;

  localparam int TBL_AW    = 4;
  localparam int DEPTH     = 16;
  localparam int WAIT_UNIT = 10;
  localparam int POLL_MAX  = 4;
`ifdef CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [TBL_AW-1:0] tbl_addr;
  logic [19:0]       tbl_data = 20'd0;
  logic              wr_req, wr_end, rd_req, rd_end;
  logic [9:0]        wr_addr, rd_addr;
  logic [7:0]        wr_data;
  logic [7:0]        rd_data = 8'd0;

  logic resp_wr_end = 1'b0, resp_rd_end = 1'b0;
  logic spur_wr_end = 1'b0, spur_rd_end = 1'b0;
  assign wr_end = resp_wr_end | spur_wr_end;
  assign rd_end = resp_rd_end | spur_rd_end;

  ad9361_cfg_seq #(.TBL_AW(TBL_AW), .WAIT_UNIT(WAIT_UNIT), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .wr_req(wr_req), .wr_end(wr_end), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Init table with a registered read port.
  logic [19:0] tbl [DEPTH];
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  // Register contents seen by reads: preset by the stimulus, overlaid by DUT writes.
  logic [7:0] spi_mem    [1024];
  logic [7:0] shadow     [1024];
  bit         shadow_vld [1024];
  logic [7:0] ovr [8];
  int         ovr_n = 0;
  int         ovr_i = 0;

  always begin : responder
    logic [9:0] a;
    logic [7:0] d;
    int lat;
    @(negedge clk);
    if (start) begin
      for (int i = 0; i < 1024; i++) shadow_vld[i] = 1'b0;
      ovr_i = 0;
    end
    if (wr_req) begin
      a = wr_addr; d = wr_data; lat = $urandom_range(1, 4);
      repeat (lat) @(posedge clk);
      #1;
      shadow[a] = d; shadow_vld[a] = 1'b1; resp_wr_end = 1'b1;
      @(posedge clk); #1 resp_wr_end = 1'b0;
    end else if (rd_req) begin
      a = rd_addr; lat = $urandom_range(1, 4);
      repeat (lat) @(posedge clk);
      #1;
      if (ovr_i < ovr_n) begin
        rd_data = ovr[ovr_i]; ovr_i++;
      end else begin
        rd_data = shadow_vld[a] ? shadow[a] : spi_mem[a];
      end
      resp_rd_end = 1'b1;
      @(posedge clk); #1 resp_rd_end = 1'b0;
    end
  end

  // Transaction log and protocol watch; counts restart on every start pulse.
  wr_t obs_wr [$];
  int  n_rd = 0, n_done = 0, viol = 0;
  bit  outstanding = 1'b0;
  always @(negedge clk) begin
    if (start) begin
      obs_wr.delete(); n_rd = 0; n_done = 0;
    end
    if (!rst_n || wr_end || rd_end) outstanding = 1'b0;
    if (wr_req && rd_req) viol++;
    if (wr_req || rd_req) begin
      if (outstanding) viol++;
      outstanding = 1'b1;
    end
    if (wr_req) obs_wr.push_back(wr_t'({wr_addr, wr_data}));
    if (rd_req) n_rd++;
    if (done) n_done++;
  end

  int passed = 0, total = 0;
  wr_t exp_wr [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [19:0] cmd(input logic [1:0] op, input logic [9:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  task automatic clear_table();
    for (int i = 0; i < DEPTH; i++) tbl[i] = cmd(2'b11, 10'd0, 8'd0);
  endtask

  // Walks the table the way the command set is defined, against a private copy of the registers.
  task automatic model_run(output bit m_done, output logic [1:0] m_code, output int m_nrd);
    logic [7:0] mm [1024];
    logic [1:0] op;
    logic [9:0] a;
    logic [7:0] d;
    int  p;
    bit  fin;
    mm = spi_mem;
    exp_wr.delete();
    m_done = 1'b0; m_code = 2'b00; m_nrd = 0; p = 0; fin = 1'b0;
    while (!fin) begin
      {op, a, d} = tbl[p];
      case (op)
        2'b00: begin
          mm[a] = d;
          exp_wr.push_back(wr_t'({a, d}));
          if (RB) m_nrd++;
        end
        2'b01: ;
        2'b10: begin
          if ((mm[a] & d) == d) m_nrd++;
          else begin
            m_nrd += POLL_MAX; m_code = 2'b01; fin = 1'b1;
          end
        end
        default: begin
          m_done = 1'b1; fin = 1'b1;
        end
      endcase
      if (!fin) begin
        if (p == DEPTH - 1) begin
          m_code = 2'b11; fin = 1'b1;
        end else p++;
      end
    end
  endtask

  task automatic run_seq(input string tag, input int budget, output int cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_err_cleared"}, err, 0);
    cyc = 0;
    while (busy && cyc < budget) begin
      @(posedge clk); #1 cyc++;
    end
    check({tag, "_terminated"}, busy, 0);
  endtask

  // Called in the DONE/ERR cycle; compares outcome and SPI traffic with the model.
  task automatic check_run(input string tag, input bit m_done, input logic [1:0] m_code, input int m_nrd);
    check({tag, "_done"}, done, m_done);
    check({tag, "_err"}, err, (m_code != 2'b00));
    check({tag, "_err_code"}, err_code, m_code);
    check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), obs_wr[i], exp_wr[i]);
    @(posedge clk); #1;
    check({tag, "_nrd"}, n_rd, m_nrd);
    check({tag, "_done_pulses"}, n_done, m_done);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_protocol"}, viol, 0);
  endtask

  initial begin
    bit         m_done;
    logic [1:0] m_code;
    int         m_nrd, cyc, r;
    logic [7:0] mask;

    for (int i = 0; i < 1024; i++) spi_mem[i] = 8'h00;
    clear_table();

    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {busy, done, err, err_code, tbl_addr, wr_req, rd_req}, 0);
    check("reset_data", {wr_addr, wr_data, rd_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single write then END.
    tbl[0] = cmd(2'b00, 10'h3DF, 8'h01);
    model_run(m_done, m_code, m_nrd);
    run_seq("write", 500, cyc);
    check_run("write", m_done, m_code, m_nrd);

    // WAIT 3 x 10 cycles; a second start mid-sequence must be ignored.
    clear_table();
    tbl[0] = cmd(2'b01, 10'h000, 8'd3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      @(posedge clk); #1 cyc++;
      start = (cyc == 10);
    end
    start = 1'b0;
    check("wait_latency_32_to_36", (cyc >= 32 && cyc <= 36), 1);
    check("wait_done", done, 1);
    check("wait_no_wr", obs_wr.size(), 0);
    check("wait_no_rd", n_rd, 0);
    repeat (2) @(posedge clk);
    #1;

    // POLL succeeds on the third read.
    clear_table();
    tbl[0] = cmd(2'b10, 10'h017, 8'h80);
    ovr[0] = 8'h00; ovr[1] = 8'h00; ovr[2] = 8'h81; ovr_n = 3;
    run_seq("poll_ok", 500, cyc);
    check("poll_ok_done", done, 1);
    check("poll_ok_err", err, 0);
    @(posedge clk); #1;
    check("poll_ok_nrd", n_rd, 3);
    ovr_n = 0;

    // POLL never satisfied: timeout after POLL_MAX reads.
    spi_mem[10'h017] = 8'h00;
    model_run(m_done, m_code, m_nrd);
    run_seq("poll_to", 500, cyc);
    check_run("poll_to", m_done, m_code, m_nrd);
    check("poll_to_err_sticky", {err, err_code}, {1'b1, 2'b01});

    // Readback mismatch, then matching readback.
    clear_table();
    tbl[0] = cmd(2'b00, 10'h002, 8'h5E);
    ovr[0] = 8'h5F; ovr_n = 1;
    run_seq("rdbk_bad", 500, cyc);
    check("rdbk_bad_done", done, !RB);
    check("rdbk_bad_code", err_code, RB ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    check("rdbk_bad_nrd", n_rd, RB ? 1 : 0);
    ovr_n = 0;
    model_run(m_done, m_code, m_nrd);
    run_seq("rdbk_ok", 500, cyc);
    check_run("rdbk_ok", m_done, m_code, m_nrd);

    // Table with no END: overrun on the last entry.
    for (int i = 0; i < DEPTH; i++) tbl[i] = cmd(2'b01, 10'h000, 8'd0);
    model_run(m_done, m_code, m_nrd);
    run_seq("overrun", 1000, cyc);
    check_run("overrun", m_done, m_code, m_nrd);

    // Reset while waiting for wr_end, spurious ends afterwards, then a clean rerun.
    clear_table();
    tbl[0] = cmd(2'b00, 10'h155, 8'hA5);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!wr_req && cyc < 20) begin
      @(posedge clk); #1 cyc++;
    end
    check("rst_saw_wr_req", wr_req, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {busy, done, err, err_code, tbl_addr, wr_req, rd_req}, 0);
    check("rst_mid_data", {wr_addr, wr_data, rd_addr}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 spur_wr_end = 1'b1;
    @(posedge clk); #1 spur_wr_end = 1'b0; spur_rd_end = 1'b1;
    @(posedge clk); #1 spur_rd_end = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_quiet_busy", busy, 0);
    check("rst_quiet_wr", obs_wr.size(), 1);
    check("rst_quiet_rd", n_rd, 0);
    check("rst_quiet_state", {done, err, tbl_addr}, 0);
    model_run(m_done, m_code, m_nrd);
    run_seq("rst_rerun", 500, cyc);
    check_run("rst_rerun", m_done, m_code, m_nrd);

    // Random tables over a small register window so writes and polls interact.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) spi_mem[i] = 8'($urandom);
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 9);
        mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
        if (r < 4)      tbl[i] = cmd(2'b00, 10'($urandom_range(0, 7)), 8'($urandom));
        else if (r < 6) tbl[i] = cmd(2'b01, 10'($urandom), 8'($urandom_range(0, 3)));
        else if (r < 9) tbl[i] = cmd(2'b10, 10'($urandom_range(0, 7)), mask);
        else            tbl[i] = cmd(2'b11, 10'($urandom), 8'($urandom));
      end
      model_run(m_done, m_code, m_nrd);
      run_seq($sformatf("rand%0d", t), 3000, cyc);
      check_run($sformatf("rand%0d", t), m_done, m_code, m_nrd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
